// File: rtl/m2_pkg.sv
`timescale 1ns/1ps
// m2_pkg
// Shared constants and types for the M2 word serializer slice.
//   WORD_BITS      - bits per telemetry word (matches the filler's dataWord)
//   PTR_W          - width of the buffer read pointer (word index within a group)
//   GRP_W          - width of the group counter
//   IDX_W          - width of the bit index inside a word
//   GROUPS_DEFAULT - default number of groups per frame
//   state_t        - serializer FSM states
package m2_pkg;

  localparam int WORD_BITS      = 12;
  localparam int PTR_W          = 8;
  localparam int GRP_W          = 5;
  localparam int IDX_W          = 4;
  localparam int GROUPS_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    LATCH = 2'd2,
    SHIFT = 2'd3
  } state_t;

endpackage

// File: rtl/m2_bit_timer.sv
`timescale 1ns/1ps
// m2_bit_timer
// Divides the system clock into serial bit periods of BIT_DIV clocks.
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_run        advance the divider this clock
//   i_clear      force the divider back to 0 (wins over i_run)
//   o_bitStrobe  high while the divider is 0 (first clock of a bit)
//   o_halfStrobe high while the divider is BIT_DIV/2 (Manchester mid-bit)
//   o_lastCycle  high while the divider is BIT_DIV-1 (last clock of a bit)
module m2_bit_timer
  import m2_pkg::*;
#(
  parameter int BIT_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_bitStrobe,
  output logic o_halfStrobe,
  output logic o_lastCycle
);

  localparam int DIV_W = $clog2(BIT_DIV);

  logic [DIV_W-1:0] r_div;

  // Divider counts 0..BIT_DIV-1 while running and wraps at the bit boundary.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div <= '0;
    end else if (i_clear) begin
      r_div <= '0;
    end else if (i_run) begin
      if (r_div == DIV_W'(BIT_DIV - 1)) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // Strobes are qualified with i_run so nothing pulses while stopped.
  assign o_bitStrobe  = i_run && (r_div == '0);
  assign o_halfStrobe = i_run && (r_div == DIV_W'(BIT_DIV / 2));
  assign o_lastCycle  = i_run && (r_div == DIV_W'(BIT_DIV - 1));

endmodule

// File: rtl/m2_word_serializer.sv
`timescale 1ns/1ps
// m2_word_serializer
// Requests words from the M2 word filler, walks the buffer read pointer and
// group counter, and shifts each 12-bit word out MSB-first as a gapless
// serial telemetry stream toward the line driver.
// Build option: define M2_MANCHESTER_EN for Manchester (G.E. Thomas) line
// coding; the default build is NRZ. Request/strobe timing is identical.
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_enable       1 = run the stream, 0 = stop after the current word
//   i_dataWord     filler word, valid the clock after o_bufGetWord
//   o_bufGetWord   one-clock request pulse to the filler
//   o_bufRdPointer word index within the group carried by the request
//   o_grpOddity    group number carried by the request
//   o_serOut       serial line
//   o_bitStrobe    one-clock pulse aligned with the first clock of each bit
//   o_frameStart   bitStrobe of bit 11 of the word at pointer 0, group 0
module m2_word_serializer
  import m2_pkg::*;
#(
  parameter int BIT_DIV = 4,
  parameter int GROUPS  = GROUPS_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [WORD_BITS-1:0] i_dataWord,
  output logic                 o_bufGetWord,
  output logic [PTR_W-1:0]     o_bufRdPointer,
  output logic [GRP_W-1:0]     o_grpOddity,
  output logic                 o_serOut,
  output logic                 o_bitStrobe,
  output logic                 o_frameStart
);

  localparam int MSB = WORD_BITS - 1;

`ifdef M2_MANCHESTER_EN
  localparam bit MANCHESTER = 1'b1;
`else
  localparam bit MANCHESTER = 1'b0;
`endif

  state_t               r_state;
  state_t               w_nextState;
  logic                 w_issueReq;
  logic                 w_load;
  logic                 w_shifting;
  logic                 w_bitStrobe;
  logic                 w_halfStrobe;
  logic                 w_lastCycle;
  logic                 w_secondHalf;
  logic                 w_lineBit;
  logic [WORD_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_idx;
  logic [PTR_W-1:0]     r_nextPtr;
  logic [GRP_W-1:0]     r_nextGrp;
  logic [PTR_W-1:0]     r_ptr;
  logic [GRP_W-1:0]     r_grp;
  logic                 r_bufGetWord;
  logic                 r_serOut;
  logic                 r_bitStrobe;
  logic                 r_frameStart;
  logic                 r_wordIsFrame;
  logic                 r_prefetched;
  logic                 r_secondHalf;

  assign w_shifting = (r_state == SHIFT);

  m2_bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_bitTimer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_run        (w_shifting),
    .i_clear      (!w_shifting),
    .o_bitStrobe  (w_bitStrobe),
    .o_halfStrobe (w_halfStrobe),
    .o_lastCycle  (w_lastCycle)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and request decision. The prefetch request is decided on the
  // last clock of bit 1 so the registered pulse, and the pointer it carries,
  // appear on the first clock of bit 0; the filler answer is then ready well
  // before the word boundary.
  always_comb begin
    w_nextState = r_state;
    w_issueReq  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_enable) begin
          w_nextState = REQ;
          w_issueReq  = 1'b1;
        end
      end
      REQ: begin
        w_nextState = LATCH;
      end
      LATCH: begin
        w_nextState = SHIFT;
      end
      SHIFT: begin
        if ((r_idx == IDX_W'(1)) && w_lastCycle && i_enable) begin
          w_issueReq = 1'b1;
        end
        if ((r_idx == '0) && w_lastCycle && !r_prefetched) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // A word is taken either after a cold request or at the final clock of the
  // previous word when a prefetch is outstanding, which keeps words gapless.
  assign w_load = (r_state == LATCH) ||
                  (w_shifting && (r_idx == '0) && w_lastCycle && r_prefetched);

  // Manchester: second half of each bit carries the inverted level.
  assign w_secondHalf = w_halfStrobe || r_secondHalf;
  assign w_lineBit    = r_shift[MSB] ^ (MANCHESTER & w_secondHalf);

  // Pointer bookkeeping: a request publishes the next pointer/group, and the
  // group advances when the pointer wraps, so pointer 0 goes out together
  // with the already-advanced group.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_nextPtr    <= '0;
      r_nextGrp    <= '0;
      r_ptr        <= '0;
      r_grp        <= '0;
      r_bufGetWord <= 1'b0;
      r_prefetched <= 1'b0;
    end else begin
      r_bufGetWord <= w_issueReq;
      if (w_issueReq) begin
        r_ptr     <= r_nextPtr;
        r_grp     <= r_nextGrp;
        r_nextPtr <= r_nextPtr + 1'b1;
        if (r_nextPtr == '1) begin
          if (r_nextGrp == GRP_W'(GROUPS - 1)) begin
            r_nextGrp <= '0;
          end else begin
            r_nextGrp <= r_nextGrp + 1'b1;
          end
        end
      end
      if (w_load) begin
        r_prefetched <= 1'b0;
      end else if (w_issueReq) begin
        r_prefetched <= 1'b1;
      end
    end
  end

  // Shift register and bit index, plus the registered line outputs. Line
  // outputs lag the internal divider by one clock so bitStrobe and
  // frameStart line up with the first clock of each bit on serOut.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift       <= '0;
      r_idx         <= '0;
      r_wordIsFrame <= 1'b0;
      r_secondHalf  <= 1'b0;
      r_serOut      <= 1'b0;
      r_bitStrobe   <= 1'b0;
      r_frameStart  <= 1'b0;
    end else begin
      if (w_load) begin
        r_shift       <= i_dataWord;
        r_idx         <= IDX_W'(MSB);
        r_wordIsFrame <= (r_ptr == '0) && (r_grp == '0);
      end else if (w_shifting && w_lastCycle && (r_idx != '0)) begin
        r_shift <= {r_shift[MSB-1:0], 1'b0};
        r_idx   <= r_idx - 1'b1;
      end

      if (w_lastCycle || !w_shifting) begin
        r_secondHalf <= 1'b0;
      end else if (w_halfStrobe) begin
        r_secondHalf <= 1'b1;
      end

      r_serOut     <= w_shifting ? w_lineBit : 1'b0;
      r_bitStrobe  <= w_bitStrobe;
      r_frameStart <= w_bitStrobe && (r_idx == IDX_W'(MSB)) && r_wordIsFrame;
    end
  end

  assign o_bufGetWord   = r_bufGetWord;
  assign o_bufRdPointer = r_ptr;
  assign o_grpOddity    = r_grp;
  assign o_serOut       = r_serOut;
  assign o_bitStrobe    = r_bitStrobe;
  assign o_frameStart   = r_frameStart;

endmodule
